// File: rtl/instr_fetch_unit_if.sv
// Signal bundle between the fetch unit, instruction memory, the redirect
// source and the decoder. The fetch unit side uses the master modport.
interface instr_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ack;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        instr_accept;
    logic        instr_valid;
    logic [31:0] instr;
    logic [5:0]  op;
    logic [31:0] pc;
    logic [31:0] pcplus4;

    // Memory handshake: a word transfers in any cycle where imem_req && imem_ack;
    // imem_addr is held while imem_req stays high. The decoder consumes the
    // presented instruction in any cycle where instr_valid && instr_accept.
    modport master (
        output imem_req, imem_addr, instr_valid, instr, op, pc, pcplus4,
        input  imem_rdata, imem_ack, redirect, redirect_pc, instr_accept
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, instr, op, pc, pcplus4,
        output imem_rdata, imem_ack, redirect, redirect_pc, instr_accept
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the program counter, fetches over req/ack, presents one
// instruction at a time to the decoder and drops fetches made stale by redirects.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                       clk,
    input  logic                       reset,
    instr_fetch_unit_if.master         bus,
    output logic [1:0]                 state_dbg
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

    state_t      state;
    logic [31:0] fetch_pc;
    logic [31:0] pend_pc;
    logic [31:0] instr_reg;
    logic [31:0] pc_reg;
    logic        valid_reg;
    logic [31:0] target_pc;
    logic [31:0] instr_out;

    assign target_pc = {bus.redirect_pc[31:2], 2'b00};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= FETCH;
            fetch_pc  <= RESET_PC_ALIGNED;
            pend_pc   <= 32'h0;
            instr_reg <= 32'h0;
            pc_reg    <= 32'h0;
            valid_reg <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (bus.imem_ack) begin
                        if (bus.redirect) begin
                            fetch_pc <= target_pc;
                        end else begin
                            instr_reg <= bus.imem_rdata;
                            pc_reg    <= fetch_pc;
                            fetch_pc  <= fetch_pc + 32'd4;
                            valid_reg <= 1'b1;
                            state     <= HOLD;
                        end
                    end else if (bus.redirect) begin
                        // The request in flight cannot be withdrawn; park the target.
                        pend_pc <= target_pc;
                        state   <= DRAIN;
                    end
                end
                HOLD: begin
                    if (bus.redirect) begin
                        fetch_pc  <= target_pc;
                        valid_reg <= 1'b0;
                        state     <= FETCH;
                    end else if (bus.instr_accept) begin
                        valid_reg <= 1'b0;
                        state     <= FETCH;
                    end
                end
                DRAIN: begin
                    if (bus.imem_ack) begin
                        fetch_pc <= bus.redirect ? target_pc : pend_pc;
                        state    <= FETCH;
                    end else if (bus.redirect) begin
                        pend_pc <= target_pc;
                    end
                end
                default: begin
                    valid_reg <= 1'b0;
                    state     <= FETCH;
                end
            endcase
        end
    end

    // Gating with reset makes the request drop the instant reset rises.
    assign bus.imem_req    = !reset && (state != HOLD);
    assign bus.imem_addr   = fetch_pc;
    assign bus.instr_valid = valid_reg;
    assign instr_out       = valid_reg ? instr_reg : 32'h0;
    assign bus.instr       = instr_out;
    assign bus.op          = instr_out[31:26];
    assign bus.pc          = pc_reg;
    assign bus.pcplus4     = pc_reg + 32'd4;
    assign state_dbg       = state;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: one instance at the default reset PC,
// one at 32'hFFFF_FFFC for the wrap-around case.
module tb_instr_fetch_unit;

    logic clk;
    logic reset;
    logic reset2;
    logic [1:0] state_dbg;
    logic [1:0] state_dbg2;
    int checks;
    int errors;

    instr_fetch_unit_if bus ();
    instr_fetch_unit_if bus2 ();

    instr_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus.master),
        .state_dbg (state_dbg)
    );

    instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
        .clk       (clk),
        .reset     (reset2),
        .bus       (bus2.master),
        .state_dbg (state_dbg2)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_hold(input string tag, input logic [31:0] exp_instr, input logic [31:0] exp_pc);
        check({tag, " valid"}, {31'h0, bus.instr_valid}, 32'd1);
        check({tag, " req"}, {31'h0, bus.imem_req}, 32'd0);
        check({tag, " instr"}, bus.instr, exp_instr);
        check({tag, " op"}, {26'h0, bus.op}, {26'h0, exp_instr[31:26]});
        check({tag, " pc"}, bus.pc, exp_pc);
        check({tag, " pcplus4"}, bus.pcplus4, exp_pc + 32'd4);
    endtask

    task automatic check_fetch(input string tag, input logic [31:0] exp_addr);
        check({tag, " valid"}, {31'h0, bus.instr_valid}, 32'd0);
        check({tag, " req"}, {31'h0, bus.imem_req}, 32'd1);
        check({tag, " addr"}, bus.imem_addr, exp_addr);
        check({tag, " instr"}, bus.instr, 32'h0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        reset2 = 1'b1;
        bus.imem_rdata = 32'h0; bus.imem_ack = 1'b0; bus.redirect = 1'b0;
        bus.redirect_pc = 32'h0; bus.instr_accept = 1'b0;
        bus2.imem_rdata = 32'h0; bus2.imem_ack = 1'b0; bus2.redirect = 1'b0;
        bus2.redirect_pc = 32'h0; bus2.instr_accept = 1'b0;

        #3;
        check("rst req", {31'h0, bus.imem_req}, 32'd0);
        check("rst valid", {31'h0, bus.instr_valid}, 32'd0);
        check("rst instr", bus.instr, 32'h0);
        check("rst pc", bus.pc, 32'h0);
        check("rst state", {30'h0, state_dbg}, 32'd0);
        check("rst2 req", {31'h0, bus2.imem_req}, 32'd0);

        step();
        reset = 1'b0;
        #1;

        // Zero-wait memory, accept held high: 0 -> 4 -> 8.
        check_fetch("t1 f0", 32'h0);
        bus.instr_accept = 1'b1;
        bus.imem_ack = 1'b1; bus.imem_rdata = 32'h8C41_0000;
        step();
        check_hold("t1 h0", 32'h8C41_0000, 32'h0);
        check("t1 h0 opval", {26'h0, bus.op}, 32'h23);
        check("t1 h0 state", {30'h0, state_dbg}, 32'd1);
        step();
        check_fetch("t1 f1", 32'h4);
        bus.imem_rdata = 32'h2002_0005;
        step();
        check_hold("t1 h1", 32'h2002_0005, 32'h4);
        step();
        check_fetch("t1 f2", 32'h8);
        bus.imem_rdata = 32'hAC43_0004;
        step();
        check_hold("t1 h2", 32'hAC43_0004, 32'h8);

        // Redirect in HOLD at pc=8 wins over the simultaneous accept.
        bus.imem_ack = 1'b0;
        bus.redirect = 1'b1; bus.redirect_pc = 32'h40;
        step();
        bus.redirect = 1'b0;
        check_fetch("t3 f", 32'h40);
        check("t3 state", {30'h0, state_dbg}, 32'd0);

        // Redirect coinciding with ack: data dropped, low target bits cleared.
        bus.imem_ack = 1'b1; bus.imem_rdata = 32'hDEAD_BEEF;
        bus.redirect = 1'b1; bus.redirect_pc = 32'h13;
        step();
        bus.redirect = 1'b0;
        check_fetch("t5a f", 32'h10);

        // Ack delayed three cycles at 0x10, address must stay put.
        bus.imem_ack = 1'b0; bus.imem_rdata = 32'h1111_1111;
        for (int i = 0; i < 3; i++) begin
            step();
            check_fetch($sformatf("t2 wait%0d", i), 32'h10);
        end
        bus.imem_ack = 1'b1; bus.imem_rdata = 32'h0C00_0100;
        bus.instr_accept = 1'b0;
        step();
        bus.imem_ack = 1'b0; bus.imem_rdata = 32'h2222_2222;
        for (int i = 0; i < 5; i++) begin
            check_hold($sformatf("t2 stall%0d", i), 32'h0C00_0100, 32'h10);
            step();
        end
        check_hold("t2 stall5", 32'h0C00_0100, 32'h10);
        bus.instr_accept = 1'b1;
        step();
        check_fetch("t2 next", 32'h14);

        // Redirect with ack pending -> DRAIN; second redirect replaces the first.
        bus.redirect = 1'b1; bus.redirect_pc = 32'h80;
        step();
        check_fetch("t4 drain0", 32'h14);
        check("t4 state", {30'h0, state_dbg}, 32'd2);
        bus.redirect_pc = 32'h90;
        step();
        check_fetch("t4 drain1", 32'h14);
        bus.redirect = 1'b0;
        bus.imem_ack = 1'b1; bus.imem_rdata = 32'hFFFF_FFFF;
        step();
        check_fetch("t4 f", 32'h90);
        bus.imem_rdata = 32'h1000_0003;
        step();
        check_hold("t4 h", 32'h1000_0003, 32'h90);
        step();
        check_fetch("t4 next", 32'h94);

        // Redirect to 0x2 on the ack cycle.
        bus.imem_rdata = 32'hBAD0_BAD0;
        bus.redirect = 1'b1; bus.redirect_pc = 32'h2;
        step();
        bus.redirect = 1'b0;
        check_fetch("t5 f", 32'h0);

        // Capture one word, then assert reset asynchronously between edges.
        bus.imem_rdata = 32'h3C01_1234;
        bus.instr_accept = 1'b0;
        step();
        check_hold("t6 h", 32'h3C01_1234, 32'h0);
        bus.imem_ack = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check("t6 req", {31'h0, bus.imem_req}, 32'd0);
        check("t6 valid", {31'h0, bus.instr_valid}, 32'd0);
        check("t6 instr", bus.instr, 32'h0);
        check("t6 pc", bus.pc, 32'h0);
        check("t6 addr", bus.imem_addr, 32'h0);

        // Second instance: reset PC at the top of the address space.
        step();
        reset2 = 1'b0;
        #1;
        check("t7 req", {31'h0, bus2.imem_req}, 32'd1);
        check("t7 addr", bus2.imem_addr, 32'hFFFF_FFFC);
        bus2.imem_ack = 1'b1; bus2.imem_rdata = 32'h2108_0001;
        bus2.instr_accept = 1'b1;
        step();
        check("t7 valid", {31'h0, bus2.instr_valid}, 32'd1);
        check("t7 pc", bus2.pc, 32'hFFFF_FFFC);
        check("t7 pcplus4", bus2.pcplus4, 32'h0);
        check("t7 op", {26'h0, bus2.op}, 32'h08);
        step();
        check("t7 next req", {31'h0, bus2.imem_req}, 32'd1);
        check("t7 next addr", bus2.imem_addr, 32'h0);
        check("t7 next valid", {31'h0, bus2.instr_valid}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
